detect_event_monitor: RTL and testbench
=======================================

Name: detect_event_monitor

Overview:
- Downstream consumer of a single-bit sequence-detector output (mealy or moore pattern-detect flag).
- Counts detections in fixed, back-to-back windows of WINDOW cycles and keeps a saturating total.
- Tracks the minimum spacing between consecutive detections.
- Raises a sticky alarm when the detections in one window reach a programmable threshold.

Parameters:
- CNT_W, 8, width of all detection counters (saturating).
- GAP_W, 10, width of the gap counter and min_gap (saturating).
- WINDOW, 100, window length in clock cycles; legal range 2..2^GAP_W-1.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- rst  input  1  synchronous reset, active-high; highest priority.
- enable  input  1  1 = monitor runs; 0 = monitor idles.
- det_in  input  1  detector output; each cycle it is high counts as one detection.
- threshold  input  CNT_W  alarm level per window; 0 disables the alarm.
- clear  input  1  synchronous statistics clear; priority below rst.
- win_count  output  CNT_W  detections so far in the current window.
- last_count  output  CNT_W  detections in the last completed window.
- total_count  output  CNT_W  detections since reset or clear.
- win_done  output  1  one-cycle pulse after each window completes.
- alarm  output  1  sticky alarm flag.
- min_gap  output  GAP_W  smallest detection-to-detection spacing seen, in cycles.

Behaviour:
- All outputs are registered.
- Reset values: win_count, last_count, total_count, win_done and alarm are 0. min_gap is all-ones. State is IDLE. The cycle counter cyc is 0. The gap tracker is empty (no previous detection).
- States: IDLE and RUN.
  - IDLE -> RUN when enable=1. The IDLE cycle itself is not counted (one-cycle arm latency). The first RUN cycle has cyc=0.
  - RUN -> IDLE when enable=0. det_in in that cycle is ignored.
  - On entry to IDLE: cyc and win_count go to 0 (partial window discarded), no win_done, gap tracker emptied. last_count, total_count, min_gap and alarm hold.
- In RUN, each cycle:
  - If det_in=1: win_count and total_count each increment by 1, saturating at 2^CNT_W-1.
  - cyc increments each cycle. When cyc==WINDOW-1:
    - last_count <= win_count plus that cycle's det_in, saturating (a detection in the final cycle belongs to the ending window).
    - win_count <= 0, cyc <= 0.
    - win_done = 1 in the next cycle only.
- Gap tracking, RUN only:
  - The gap counter increments every cycle and saturates at 2^GAP_W-1.
  - On a detection: if a previous detection exists, gap = cycles since it (consecutive cycles give gap=1), and min_gap <= min(min_gap, gap). Then the gap counter restarts and the tracker is marked non-empty.
  - The first detection after rst, clear or IDLE records no gap.
- Alarm:
  - With threshold != 0, alarm goes high in the cycle after the detection that makes the window count (including that detection) >= threshold.
  - The final-cycle detection of a window is evaluated against the ending window.
  - Once set, alarm stays high across windows, IDLE and threshold changes. Only rst or clear lowers it.
- clear=1:
  - win_count, last_count, total_count, cyc, win_done and alarm go to 0. min_gap goes to all-ones. Gap tracker is emptied.
  - State is unchanged. det_in in the clear cycle is ignored.
  - A window boundary coinciding with clear produces no win_done.
- rst during RUN behaves exactly as power-on reset, and overrides clear and enable.
- threshold is sampled every cycle; no latching.

Test Plan:
- Bench parameters: CNT_W=4, GAP_W=6, WINDOW=16.
- Reset: rst high 5 cycles with det_in toggling -> win_count=0, last_count=0, total_count=0, win_done=0, alarm=0, min_gap=63.
- Basic window: threshold=0, enable=1, det_in high at RUN cycles 3, 6, 12 -> win_count steps 1/2/3. After cycle 15: win_done pulses one cycle, last_count=3, win_count=0, total_count=3, min_gap=3, alarm=0.
- Boundary detection: det_in high only at cyc=15 -> last_count=1, next window's win_count=0, total_count=1.
- Alarm: threshold=3, detections at cycles 2, 4, 5 -> alarm=1 in the cycle after cycle 5, min_gap=1. Alarm stays 1 through the next two windows with no detections. A clear pulse -> alarm=0 and all counters 0.
- Saturation: det_in held high 20 RUN cycles -> win_count=15, total_count=15, last_count=15 at the first boundary, min_gap=1.
- Enable drop: 2 detections, then enable=0 at cyc=8 -> win_count=0, total_count=2, no win_done. Re-enable -> first counted cycle is one cycle later, and the next win_done arrives 16 RUN cycles after that.

Source files
------------

// File: rtl/detect_event_monitor_if.sv
// Handshake bundle between a sequence detector stage and its event monitor.
// master drives control/detections, slave (the monitor) returns statistics.
interface detect_event_monitor_if #(
  parameter int CNT_W = 8,
  parameter int GAP_W = 10
);
  logic             enable;
  logic             det_in;
  logic [CNT_W-1:0] threshold;
  logic             clear;
  logic [CNT_W-1:0] win_count;
  logic [CNT_W-1:0] last_count;
  logic [CNT_W-1:0] total_count;
  logic             win_done;
  logic             alarm;
  logic [GAP_W-1:0] min_gap;

  modport master (
    output enable, det_in, threshold, clear,
    input  win_count, last_count, total_count, win_done, alarm, min_gap
  );
  modport slave (
    input  enable, det_in, threshold, clear,
    output win_count, last_count, total_count, win_done, alarm, min_gap
  );
endinterface

// File: rtl/detect_event_monitor.sv
// Windowed detection counter with saturating totals, minimum detection spacing
// tracker and a sticky per-window threshold alarm.
module detect_event_monitor #(
  parameter int CNT_W  = 8,
  parameter int GAP_W  = 10,
  parameter int WINDOW = 100
) (
  input  logic                   clk,
  input  logic                   rst,
  detect_event_monitor_if.slave  bus
);
  typedef enum logic {IDLE, RUN} state_e;

  localparam logic [GAP_W-1:0] LAST_CYC = GAP_W'(WINDOW - 1);

  state_e           state_q, state_d;
  logic [GAP_W-1:0] cyc_q, cyc_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             gap_vld_q, gap_vld_d;
  logic [GAP_W-1:0] min_gap_q, min_gap_d;
  logic [CNT_W-1:0] win_q, win_d;
  logic [CNT_W-1:0] last_q, last_d;
  logic [CNT_W-1:0] tot_q, tot_d;
  logic             win_done_q, win_done_d;
  logic             alarm_q, alarm_d;
  logic [CNT_W-1:0] win_inc;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
    return (inc && v != '1) ? v + CNT_W'(1) : v;
  endfunction

  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    gap_d      = gap_q;
    gap_vld_d  = gap_vld_q;
    min_gap_d  = min_gap_q;
    win_d      = win_q;
    last_d     = last_q;
    tot_d      = tot_q;
    win_done_d = 1'b0;
    alarm_d    = alarm_q;
    // window count including this cycle's detection; also what the alarm sees
    win_inc    = sat_inc(win_q, bus.det_in);

    if (bus.clear) begin
      cyc_d     = '0;
      gap_d     = '0;
      gap_vld_d = 1'b0;
      min_gap_d = '1;
      win_d     = '0;
      last_d    = '0;
      tot_d     = '0;
      alarm_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.enable) state_d = RUN;
        RUN: begin
          if (!bus.enable) begin
            state_d   = IDLE;
            cyc_d     = '0;
            win_d     = '0;
            gap_vld_d = 1'b0;
          end else begin
            tot_d = sat_inc(tot_q, bus.det_in);
            gap_d = (gap_q == '1) ? gap_q : gap_q + GAP_W'(1);
            if (bus.det_in) begin
              if (gap_vld_q && gap_q < min_gap_q) min_gap_d = gap_q;
              // next cycle is one cycle after this detection
              gap_d     = GAP_W'(1);
              gap_vld_d = 1'b1;
              if (bus.threshold != '0 && win_inc >= bus.threshold) alarm_d = 1'b1;
            end
            if (cyc_q == LAST_CYC) begin
              last_d     = win_inc;
              win_d      = '0;
              cyc_d      = '0;
              win_done_d = 1'b1;
            end else begin
              win_d = win_inc;
              cyc_d = cyc_q + GAP_W'(1);
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cyc_q      <= '0;
      gap_q      <= '0;
      gap_vld_q  <= 1'b0;
      min_gap_q  <= '1;
      win_q      <= '0;
      last_q     <= '0;
      tot_q      <= '0;
      win_done_q <= 1'b0;
      alarm_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cyc_q      <= cyc_d;
      gap_q      <= gap_d;
      gap_vld_q  <= gap_vld_d;
      min_gap_q  <= min_gap_d;
      win_q      <= win_d;
      last_q     <= last_d;
      tot_q      <= tot_d;
      win_done_q <= win_done_d;
      alarm_q    <= alarm_d;
    end
  end

  assign bus.win_count   = win_q;
  assign bus.last_count  = last_q;
  assign bus.total_count = tot_q;
  assign bus.win_done    = win_done_q;
  assign bus.alarm       = alarm_q;
  assign bus.min_gap     = min_gap_q;
endmodule

// File: tb/tb_detect_event_monitor.sv
// Directed test-plan scenarios followed by random traffic, all checked every
// cycle against an event-level model (timestamps and unbounded counts).
module tb_detect_event_monitor;
  localparam int CNT_W = 4;
  localparam int GAP_W = 6;
  localparam int WIN   = 16;
  localparam int CMAX  = (1 << CNT_W) - 1;
  localparam int GMAX  = (1 << GAP_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  detect_event_monitor_if #(.CNT_W(CNT_W), .GAP_W(GAP_W)) bus ();
  detect_event_monitor #(.CNT_W(CNT_W), .GAP_W(GAP_W), .WINDOW(WIN)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int checks = 0;
  int fails  = 0;

  // model: running flag, position in window, unbounded counts, timestamps
  bit m_run, m_done, m_alarm, m_hp;
  int m_pos, m_w, m_tot, m_last, m_mg, m_prev, t;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d t=%0d", tag, got, exp, t);
    end
  endtask

  function automatic int mn(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic mreset();
    m_run = 0; m_done = 0; m_alarm = 0; m_hp = 0;
    m_pos = 0; m_w = 0; m_tot = 0; m_last = 0; m_mg = GMAX;
  endtask

  task automatic step(input bit r, input bit en, input bit d, input bit clr, input int thr);
    rst = r; bus.enable = en; bus.det_in = d; bus.clear = clr;
    bus.threshold = CNT_W'(thr);
    m_done = 0;
    if (r) mreset();
    else if (clr) begin
      m_w = 0; m_last = 0; m_tot = 0; m_pos = 0; m_alarm = 0; m_mg = GMAX; m_hp = 0;
    end else if (!m_run) begin
      if (en) m_run = 1;
    end else if (!en) begin
      m_run = 0; m_pos = 0; m_w = 0; m_hp = 0;
    end else begin
      if (d) begin
        m_w++; m_tot++;
        if (m_hp) m_mg = mn(m_mg, mn(t - m_prev, GMAX));
        m_prev = t; m_hp = 1;
        if (thr != 0 && m_w >= thr) m_alarm = 1;
      end
      if (m_pos == WIN - 1) begin
        m_last = mn(m_w, CMAX); m_w = 0; m_pos = 0; m_done = 1;
      end else m_pos++;
    end
    @(posedge clk); #1;
    t++;
    chk("win_count",   int'(bus.win_count),   mn(m_w, CMAX));
    chk("last_count",  int'(bus.last_count),  m_last);
    chk("total_count", int'(bus.total_count), mn(m_tot, CMAX));
    chk("win_done",    int'(bus.win_done),    int'(m_done));
    chk("alarm",       int'(bus.alarm),       int'(m_alarm));
    chk("min_gap",     int'(bus.min_gap),     m_mg);
  endtask

  initial begin
    t = 0; m_prev = 0;
    mreset();
    bus.enable = 0; bus.det_in = 0; bus.clear = 0; bus.threshold = '0;

    // reset with det toggling
    for (int i = 0; i < 5; i++) step(1, 1, i[0], 0, 0);
    chk("rst_min_gap", int'(bus.min_gap), 63);
    chk("rst_alarm", int'(bus.alarm), 0);

    // basic window: arm cycle then detections at 3, 6, 12
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < WIN; i++) step(0, 1, (i == 3 || i == 6 || i == 12), 0, 0);
    chk("bw_done", int'(bus.win_done), 1);
    chk("bw_last", int'(bus.last_count), 3);
    chk("bw_total", int'(bus.total_count), 3);
    chk("bw_min_gap", int'(bus.min_gap), 3);
    step(0, 1, 0, 0, 0);
    chk("bw_done_pulse", int'(bus.win_done), 0);

    // boundary detection only in final cycle
    step(0, 1, 0, 1, 0);
    for (int i = 0; i < WIN; i++) step(0, 1, (i == WIN - 1), 0, 0);
    chk("bd_last", int'(bus.last_count), 1);
    chk("bd_win", int'(bus.win_count), 0);
    step(0, 1, 0, 0, 0);

    // alarm at threshold 3, sticky through two empty windows, then clear
    step(0, 1, 0, 1, 3);
    for (int i = 0; i < WIN; i++) step(0, 1, (i == 2 || i == 4 || i == 5), 0, 3);
    chk("al_min_gap", int'(bus.min_gap), 1);
    for (int i = 0; i < 2 * WIN; i++) step(0, 1, 0, 0, 3);
    chk("al_sticky", int'(bus.alarm), 1);
    step(0, 1, 0, 1, 3);
    chk("al_clear", int'(bus.alarm), 0);

    // saturation
    for (int i = 0; i < 20; i++) step(0, 1, 1, 0, 0);
    chk("sat_total", int'(bus.total_count), 15);
    chk("sat_last", int'(bus.last_count), 15);

    // enable drop at cyc 8, then re-arm
    step(0, 1, 0, 1, 0);
    for (int i = 0; i < 8; i++) step(0, 1, (i == 1 || i == 3), 0, 0);
    step(0, 0, 1, 0, 0);
    chk("ed_total", int'(bus.total_count), 2);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < WIN + 2; i++) step(0, 1, (i == 0), 0, 0);

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      automatic int thr = (i % 64 < 8) ? 0 : int'(($urandom >> 3) % 16);
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 19) != 0),
           ($urandom_range(0, 9) < 3), ($urandom_range(0, 99) == 0), thr);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
